// File: rtl/morra_move_collector.sv
// Front-end for the Morracinese core: collects one move per player, issues the pair
// for a single cycle, then watches the partita result to detect the end of the game.
module morra_move_collector #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_manche,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p2_ready,
    input  logic [1:0] partita_in,
    output logic       game_reset,
    output logic [1:0] g1,
    output logic [1:0] g2,
    output logic [4:0] manche_count,
    output logic       timeout,
    output logic       game_over
);

    typedef enum logic [2:0] {IDLE, CONFIG, COLLECT, ISSUE, WAIT_RES, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t           state, state_n;
    logic [3:0]       cfg, cfg_n;
    // A slot value of 00 means empty: legal moves are never 00.
    logic [1:0]       slot1, slot1_n, slot2, slot2_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             to_n, acc1, acc2;
    logic             game_reset_n, p1_ready_n, p2_ready_n, game_over_n;
    logic [1:0]       g1_n, g2_n;
    logic [4:0]       manche_n;

    // Moves offered on a restart edge are discarded along with the slots.
    assign acc1 = (state == COLLECT) && p1_valid && p1_ready && (p1_move != 2'b00) && !cfg_valid;
    assign acc2 = (state == COLLECT) && p2_valid && p2_ready && (p2_move != 2'b00) && !cfg_valid;

    always_comb begin
        state_n = state;
        cfg_n   = cfg;
        slot1_n = slot1;
        slot2_n = slot2;
        cnt_n   = cnt;
        to_n    = 1'b0;
        case (state)
            CONFIG: begin
                slot1_n = 2'b00;
                slot2_n = 2'b00;
                cnt_n   = '0;
                state_n = COLLECT;
            end
            COLLECT: begin
                if (acc1) slot1_n = p1_move;
                if (acc2) slot2_n = p2_move;
                if (acc1 || acc2) begin
                    cnt_n = '0;
                end else if (TIMEOUT_CYCLES != 0 && cnt == TO_MAX) begin
                    slot1_n = 2'b00;
                    slot2_n = 2'b00;
                    to_n    = 1'b1;
                    cnt_n   = '0;
                end else if (slot1 == 2'b00 || slot2 == 2'b00) begin
                    cnt_n = cnt + CNT_W'(1);
                end
                if (slot1_n != 2'b00 && slot2_n != 2'b00) state_n = ISSUE;
            end
            ISSUE: begin
                slot1_n = 2'b00;
                slot2_n = 2'b00;
                state_n = WAIT_RES;
            end
            WAIT_RES: begin
                cnt_n   = '0;
                state_n = (partita_in != 2'b00) ? DONE : COLLECT;
            end
            default: ;
        endcase
        if (cfg_valid) begin
            cfg_n   = cfg_manche;
            slot1_n = 2'b00;
            slot2_n = 2'b00;
            cnt_n   = '0;
            to_n    = 1'b0;
            state_n = CONFIG;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_comb begin
        game_reset_n = (state_n == IDLE) || (state_n == CONFIG);
        p1_ready_n   = (state_n == COLLECT) && (slot1_n == 2'b00);
        p2_ready_n   = (state_n == COLLECT) && (slot2_n == 2'b00);
        game_over_n  = (state_n == DONE);
        g1_n         = 2'b00;
        g2_n         = 2'b00;
        manche_n     = manche_count;
        if (state_n == CONFIG) begin
            g1_n     = cfg_n[3:2];
            g2_n     = cfg_n[1:0];
            manche_n = '0;
        end else if (state_n == ISSUE) begin
            g1_n     = slot1_n;
            g2_n     = slot2_n;
            manche_n = (manche_count == 5'd31) ? manche_count : manche_count + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cfg          <= '0;
            slot1        <= 2'b00;
            slot2        <= 2'b00;
            cnt          <= '0;
            game_reset   <= 1'b1;
            g1           <= 2'b00;
            g2           <= 2'b00;
            p1_ready     <= 1'b0;
            p2_ready     <= 1'b0;
            manche_count <= '0;
            timeout      <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            cfg          <= cfg_n;
            slot1        <= slot1_n;
            slot2        <= slot2_n;
            cnt          <= cnt_n;
            game_reset   <= game_reset_n;
            g1           <= g1_n;
            g2           <= g2_n;
            p1_ready     <= p1_ready_n;
            p2_ready     <= p2_ready_n;
            manche_count <= manche_n;
            timeout      <= to_n;
            game_over    <= game_over_n;
        end
    end

endmodule

// File: tb/tb_morra_move_collector.sv
// Directed bench for morra_move_collector with a short timeout so flushing is reachable.
module tb_morra_move_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_manche = 4'd0;
    logic       p1_valid = 1'b0;
    logic [1:0] p1_move = 2'd0;
    logic       p1_ready;
    logic       p2_valid = 1'b0;
    logic [1:0] p2_move = 2'd0;
    logic       p2_ready;
    logic [1:0] partita_in = 2'd0;
    logic       game_reset;
    logic [1:0] g1, g2;
    logic [4:0] manche_count;
    logic       timeout;
    logic       game_over;

    int n_cmp = 0;
    int n_err = 0;

    morra_move_collector #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_manche(cfg_manche),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .partita_in(partita_in), .game_reset(game_reset),
        .g1(g1), .g2(g2), .manche_count(manche_count),
        .timeout(timeout), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_g(input string tag, input logic [1:0] e1, input logic [1:0] e2);
        chk({tag, "_g1"}, 8'(g1), 8'(e1));
        chk({tag, "_g2"}, 8'(g2), 8'(e2));
    endtask

    task automatic chk_rdy(input string tag, input logic e1, input logic e2);
        chk({tag, "_p1_ready"}, 8'(p1_ready), 8'(e1));
        chk({tag, "_p2_ready"}, 8'(p2_ready), 8'(e2));
    endtask

    initial begin
        // reset values
        #1 reset = 1'b1;
        #2;
        chk("rst_game_reset", 8'(game_reset), 8'd1);
        chk_g("rst", 2'b00, 2'b00);
        chk_rdy("rst", 1'b0, 1'b0);
        chk("rst_manche", 8'(manche_count), 8'd0);
        chk("rst_timeout", 8'(timeout), 8'd0);
        chk("rst_game_over", 8'(game_over), 8'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_game_reset", 8'(game_reset), 8'd1);

        // configure with 0000
        cfg_valid = 1'b1; cfg_manche = 4'b0000;
        tick();
        chk("cfg0_game_reset", 8'(game_reset), 8'd1);
        chk_g("cfg0", 2'b00, 2'b00);
        chk_rdy("cfg0", 1'b0, 1'b0);
        cfg_valid = 1'b0;
        tick();
        chk("col0_game_reset", 8'(game_reset), 8'd0);
        chk_rdy("col0", 1'b1, 1'b1);

        // restart from COLLECT with 0110; p1 offer on the same edge is dropped
        cfg_valid = 1'b1; cfg_manche = 4'b0110;
        p1_valid = 1'b1; p1_move = 2'b01;
        tick();
        chk("cfg6_game_reset", 8'(game_reset), 8'd1);
        chk_g("cfg6", 2'b01, 2'b10);
        chk("cfg6_manche", 8'(manche_count), 8'd0);
        cfg_valid = 1'b0; p1_valid = 1'b0;
        tick();
        chk_rdy("col6", 1'b1, 1'b1);

        // p1 at t, p2 at t+3
        p1_valid = 1'b1; p1_move = 2'b01;
        tick();
        chk_rdy("p1acc", 1'b0, 1'b1);
        chk_g("p1acc", 2'b00, 2'b00);
        p1_valid = 1'b0;
        tick();
        tick();
        chk_g("wait_p2", 2'b00, 2'b00);
        p2_valid = 1'b1; p2_move = 2'b10;
        tick();
        chk_g("issue1", 2'b01, 2'b10);
        chk("issue1_manche", 8'(manche_count), 8'd1);
        chk_rdy("issue1", 1'b0, 1'b0);
        p2_valid = 1'b0;
        tick();
        chk_g("wres1", 2'b00, 2'b00);
        chk("wres1_manche", 8'(manche_count), 8'd1);
        tick();
        chk_rdy("back1", 1'b1, 1'b1);
        chk_g("back1", 2'b00, 2'b00);

        // simultaneous 11/11
        p1_valid = 1'b1; p1_move = 2'b11;
        p2_valid = 1'b1; p2_move = 2'b11;
        tick();
        chk_g("issue2", 2'b11, 2'b11);
        chk("issue2_manche", 8'(manche_count), 8'd2);
        p1_valid = 1'b0; p2_valid = 1'b0;
        tick();
        chk_rdy("wres2", 1'b0, 1'b0);
        chk_g("wres2", 2'b00, 2'b00);
        tick();
        chk_rdy("back2", 1'b1, 1'b1);

        // illegal 00 ignored, then 10 accepted, later 01 to full slot ignored
        p1_valid = 1'b1; p1_move = 2'b00;
        tick();
        chk_rdy("p1_illegal", 1'b1, 1'b1);
        p1_move = 2'b10;
        tick();
        chk_rdy("p1_10", 1'b0, 1'b1);
        p1_move = 2'b01;
        tick();
        chk_rdy("p1_full", 1'b0, 1'b1);
        p1_valid = 1'b0;
        p2_valid = 1'b1; p2_move = 2'b01;
        tick();
        chk_g("issue3", 2'b10, 2'b01);
        chk("issue3_manche", 8'(manche_count), 8'd3);
        p2_valid = 1'b0;
        tick();
        tick();
        chk_rdy("back3", 1'b1, 1'b1);

        // timeout: only p1 moves
        p1_valid = 1'b1; p1_move = 2'b11;
        tick();
        chk_rdy("to_acc", 1'b0, 1'b1);
        p1_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("to_before", 8'(timeout), 8'd0);
        chk("to_before_p1", 8'(p1_ready), 8'd0);
        tick();
        chk("to_pulse", 8'(timeout), 8'd1);
        chk_rdy("to_pulse", 1'b1, 1'b1);
        chk_g("to_pulse", 2'b00, 2'b00);
        chk("to_manche", 8'(manche_count), 8'd3);
        tick();
        chk("to_end", 8'(timeout), 8'd0);
        chk("to_end_p1", 8'(p1_ready), 8'd1);

        // game end on partita 10
        p1_valid = 1'b1; p1_move = 2'b01;
        p2_valid = 1'b1; p2_move = 2'b11;
        tick();
        chk_g("issue4", 2'b01, 2'b11);
        chk("issue4_manche", 8'(manche_count), 8'd4);
        p1_valid = 1'b0; p2_valid = 1'b0;
        partita_in = 2'b10;
        tick();
        chk("wres4_game_over", 8'(game_over), 8'd0);
        tick();
        chk("done_game_over", 8'(game_over), 8'd1);
        chk_g("done", 2'b00, 2'b00);
        chk_rdy("done", 1'b0, 1'b0);
        chk("done_game_reset", 8'(game_reset), 8'd0);
        partita_in = 2'b00;
        p1_valid = 1'b1; p1_move = 2'b10;
        p2_valid = 1'b1; p2_move = 2'b10;
        tick();
        chk("done_hold", 8'(game_over), 8'd1);
        chk_g("done_hold", 2'b00, 2'b00);
        chk("done_manche", 8'(manche_count), 8'd4);
        p1_valid = 1'b0; p2_valid = 1'b0;

        // new game, CONFIG repeated by back-to-back cfg_valid
        cfg_valid = 1'b1; cfg_manche = 4'b0000;
        tick();
        chk("cfg_new_game_over", 8'(game_over), 8'd0);
        chk("cfg_new_manche", 8'(manche_count), 8'd0);
        cfg_manche = 4'b0101;
        tick();
        chk_g("cfg_rep", 2'b01, 2'b01);
        chk("cfg_rep_game_reset", 8'(game_reset), 8'd1);
        cfg_valid = 1'b0;
        tick();
        chk_rdy("col_new", 1'b1, 1'b1);
        p1_valid = 1'b1; p1_move = 2'b10;
        p2_valid = 1'b1; p2_move = 2'b01;
        tick();
        chk("issue5_manche", 8'(manche_count), 8'd1);
        p1_valid = 1'b0; p2_valid = 1'b0;
        tick();
        tick();
        chk_rdy("back5", 1'b1, 1'b1);

        // mid-game restart with 1111
        cfg_valid = 1'b1; cfg_manche = 4'b1111;
        tick();
        chk_g("cfg15", 2'b11, 2'b11);
        chk("cfg15_game_reset", 8'(game_reset), 8'd1);
        chk("cfg15_manche", 8'(manche_count), 8'd0);
        cfg_valid = 1'b0;
        tick();
        chk_rdy("col15", 1'b1, 1'b1);

        // async reset mid-game drops the pending move
        p1_valid = 1'b1; p1_move = 2'b01;
        tick();
        chk("pre_arst_p1", 8'(p1_ready), 8'd0);
        p1_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_game_reset", 8'(game_reset), 8'd1);
        chk_rdy("arst", 1'b0, 1'b0);
        chk("arst_manche", 8'(manche_count), 8'd0);
        tick();
        reset = 1'b0;
        cfg_valid = 1'b1; cfg_manche = 4'b0000;
        tick();
        cfg_valid = 1'b0;
        tick();
        chk_rdy("post_arst", 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/morra_move_collector.md
Name: morra_move_collector

Overview:
- Upstream front-end for the Morracinese game core.
- Accepts game configuration and each player's move through independent valid/ready handshakes.
- Once both moves are held, presents the pair to the core on g1/g2 for exactly one cycle, then monitors the core's partita result.
- Drives the core's reset/configuration cycle and detects game end.

Parameters:
TIMEOUT_CYCLES, 255, COLLECT cycles allowed before the pending move slots are flushed; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
cfg_valid  in  1  start a new game with cfg_manche
cfg_manche  in  4  manchemax minus 4 (0 gives 4 manches, 15 gives 19)
p1_valid  in  1  player 1 move offered
p1_move  in  2  01 sasso, 10 carta, 11 forbice; 00 is illegal
p1_ready  out  1  player 1 slot empty and accepting
p2_valid  in  1  player 2 move offered
p2_move  in  2  same encoding as p1_move
p2_ready  out  1  player 2 slot empty and accepting
partita_in  in  2  core partita output: 00 running, 01 g1 wins, 10 g2 wins, 11 draw
game_reset  out  1  drives core reset
g1  out  2  core g1 input
g2  out  2  core g2 input
manche_count  out  5  move pairs issued in the current game, saturating at 31
timeout  out  1  one-cycle pulse when pending slots are flushed
game_over  out  1  high while in DONE

Behaviour:
- All outputs are registered.
- Reset (async) values:
  - state = IDLE, game_reset = 1, g1 = g2 = 00.
  - p1_ready = p2_ready = 0, manche_count = 0, timeout = 0, game_over = 0.
  - Both slots empty; latched configuration = 0.
- The core treats g1 = g2 = 00 with game_reset = 0 as an idle cycle: no manche is played.
- IDLE:
  - game_reset = 1, g1/g2 = 00.
  - On cfg_valid: latch cfg_manche, then go to CONFIG.
- CONFIG (1 cycle):
  - game_reset = 1, g1 = cfg[3:2], g2 = cfg[1:0].
  - Clear manche_count, both slots and the timeout counter.
  - Go to COLLECT.
- COLLECT:
  - game_reset = 0, g1/g2 = 00.
  - pX_ready = 1 while slot X is empty.
  - A move is accepted on a clock edge where pX_valid & pX_ready & pX_move != 00.
  - A 00 move is ignored; ready stays high.
  - Both players may be accepted on the same edge.
  - Offers to a full slot are ignored (ready = 0).
  - When both slots are full, go to ISSUE. Ready drops the cycle after the second acceptance.
- ISSUE (1 cycle):
  - g1/g2 = slot contents.
  - manche_count increments, saturating at 31.
  - Slots clear; go to WAIT_RES.
- WAIT_RES (1 cycle):
  - g1/g2 = 00.
  - On the closing edge, sample partita_in. If != 00, go to DONE; else go to COLLECT.
- DONE:
  - game_over = 1, g1/g2 = 00, ready = 0, game_reset = 0.
  - Core outputs are left frozen.
  - cfg_valid latches the new configuration and goes to CONFIG.
- Timeout:
  - Counter increments each COLLECT cycle while at least one slot is empty.
  - It resets on entering COLLECT and on any acceptance.
  - When the counter equals TIMEOUT_CYCLES (if nonzero): clear both slots, pulse timeout for 1 cycle, restart the count, stay in COLLECT.
  - If an acceptance and the timeout occur on the same edge, the acceptance wins and no timeout fires.
- Mid-game restart:
  - cfg_valid in COLLECT, ISSUE or WAIT_RES aborts: slots are discarded, the configuration is latched, go to CONFIG.
  - Moves offered on that same edge are not accepted.
- cfg_valid in CONFIG: the newer cfg_manche is latched and CONFIG is repeated.
- Async reset mid-game forces IDLE immediately. Moves are lost and the core is held in reset.

Test Plan:
- Reset, then cfg_valid with cfg_manche = 0000 -> next cycle game_reset = 1, g1 = 00, g2 = 00; following cycle state COLLECT, p1_ready = p2_ready = 1.
- cfg 0110; p1 offers 01 at cycle t, p2 offers 10 at t+3 -> exactly one cycle with g1 = 01, g2 = 10; manche_count = 1; g1/g2 = 00 otherwise.
- Both players offer 11/11 on the same edge with partita_in = 00 -> one ISSUE cycle, then COLLECT; ready high again 2 cycles after ISSUE.
- p1 offers 00, then 10 -> 00 ignored with p1_ready still 1; 10 accepted; a second p1 offer 01 before p2 moves is ignored (ready = 0).
- TIMEOUT_CYCLES = 4; only p1 moves -> timeout pulses once, slot 1 cleared, p1_ready = 1, no ISSUE.
- partita_in = 10 during WAIT_RES -> game_over = 1 and no further g outputs; cfg_valid with 1111 during COLLECT of a later game -> CONFIG with g1 = 11, g2 = 11, game_reset = 1, manche_count = 0.
